// File: rtl/slice_arb_pkg.sv
// rtl/slice_arb_pkg.sv - shared types and constants for the slice arbiter
package slice_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    localparam int LUT_W    = 4;
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

endpackage

// File: rtl/slice_arbiter_rr_pick.sv
// rtl/slice_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int            j;
    logic [IW-1:0] jj;

    // Scan from the pointer upward with wrap; the first requester found wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        j        = 0;
        jj       = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!valid_o && req_i[jj]) begin
                valid_o      = 1'b1;
                idx_o        = jj;
                onehot_o[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slice_arbiter.sv
// rtl/slice_arbiter.sv - round-robin sharing of one LUT/MUX/FF slice between NREQ requesters
// Optional requester lock enabled by defining SLICE_ARB_LOCK_EN.
module slice_arbiter
    import slice_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  C,
    input  logic                  RN,
    input  logic [NREQ-1:0]       REQ,
    input  logic [LUT_W*NREQ-1:0] REQ_I,
    input  logic [NREQ-1:0]       REQ_D,
    input  logic [NREQ-1:0]       REQ_S,
    output logic [NREQ-1:0]       GNT,
    output logic                  ACK,
    output logic                  RES,
    output logic [LUT_W-1:0]      SL_I,
    output logic                  SL_D,
    output logic                  SL_S,
    input  logic                  SL_Q
`ifdef SLICE_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]       LOCK
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("slice_arbiter: NREQ out of range");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              ack_q, ack_d;
    logic              res_q, res_d;
    logic [LUT_W-1:0]  sl_i_q, sl_i_d;
    logic              sl_d_q, sl_d_d;
    logic              sl_s_q, sl_s_d;

    logic [NREQ-1:0]   win_oh;
    logic [IW-1:0]     win_idx;
    logic              win_vld;
    logic [LUT_W-1:0]  fld [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .valid_o  (win_vld)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fld[i] = REQ_I[i*LUT_W +: LUT_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        res_d   = res_q;
        sl_i_d  = sl_i_q;
        sl_d_d  = sl_d_q;
        sl_s_d  = sl_s_q;
        case (state_q)
            IDLE: begin
                // Requester fields are captured only here; later changes cannot disturb the slice.
                if (win_vld) begin
                    state_d = ISSUE;
                    gnt_d   = win_oh;
                    idx_d   = win_idx;
                    sl_i_d  = fld[win_idx];
                    sl_d_d  = REQ_D[win_idx];
                    sl_s_d  = REQ_S[win_idx];
                end
            end
            ISSUE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = IDLE;
                res_d   = SL_Q;
                ack_d   = 1'b1;
                gnt_d   = '0;
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
`ifdef SLICE_ARB_LOCK_EN
                // Parking the pointer on a locked winner makes it first in line in the ACK cycle.
                if (LOCK[idx_q] && REQ[idx_q]) begin
                    ptr_d = idx_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            res_q   <= 1'b0;
            sl_i_q  <= '0;
            sl_d_q  <= 1'b0;
            sl_s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            sl_i_q  <= sl_i_d;
            sl_d_q  <= sl_d_d;
            sl_s_q  <= sl_s_d;
        end
    end

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign RES  = res_q;
    assign SL_I = sl_i_q;
    assign SL_D = sl_d_q;
    assign SL_S = sl_s_q;

endmodule

// File: tb/tb_slice_arbiter.sv
// tb/tb_slice_arbiter.sv - self-checking bench for slice_arbiter
module tb_slice_arbiter;

    localparam int N = 4;

    logic           C = 1'b0;
    logic           RN = 1'b0;
    logic [N-1:0]   REQ = '0;
    logic [4*N-1:0] REQ_I = '0;
    logic [N-1:0]   REQ_D = '0;
    logic [N-1:0]   REQ_S = '0;
    logic [N-1:0]   GNT;
    logic           ACK, RES, SL_D, SL_S;
    logic [3:0]     SL_I;
    logic           SL_Q;
    logic [15:0]    lut_init = 16'h6C5A;

    always #5 C = ~C;

    slice_arbiter #(.NREQ(N)) dut (
        .C(C), .RN(RN), .REQ(REQ), .REQ_I(REQ_I), .REQ_D(REQ_D), .REQ_S(REQ_S),
        .GNT(GNT), .ACK(ACK), .RES(RES), .SL_I(SL_I), .SL_D(SL_D), .SL_S(SL_S),
        .SL_Q(SL_Q)
    );

    // Slice: LUT with fixed INIT, bypass mux, flip-flop.
    always @(posedge C or negedge RN) begin
        if (!RN) SL_Q <= 1'b0;
        else     SL_Q <= SL_S ? SL_D : lut_init[SL_I];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge C);
        #1;
    endtask

    // Timeline model: an operation accepted at edge e owns GNT after edges e and e+1,
    // ACKs after edge e+2, and the arbiter can accept again at edge e+3.
    int           e = 0;
    bit           op_act = 0;
    int           op_start = 0;
    int           op_k = 0;
    int           m_ptr = 0;
    bit           op_res = 0;
    bit           f_m;
    int           j_m;
    logic [N-1:0] x_gnt = '0;
    logic         x_ack = 0, x_res = 0, x_sd = 0, x_ss = 0;
    logic [3:0]   x_si = '0;

    always @(posedge C or negedge RN) begin
        if (!RN) begin
            op_act = 0; m_ptr = 0;
            x_gnt = '0; x_ack = 0; x_res = 0; x_si = '0; x_sd = 0; x_ss = 0;
        end else begin
            e++;
            if (op_act && e >= op_start + 3) op_act = 0;
            if (!op_act && REQ != '0) begin
                f_m = 0;
                for (int i = 0; i < N; i++) begin
                    j_m = (m_ptr + i) % N;
                    if (!f_m && REQ[j_m]) begin
                        f_m = 1;
                        op_k = j_m;
                    end
                end
                op_act   = 1;
                op_start = e;
                x_si     = REQ_I[4*op_k +: 4];
                x_sd     = REQ_D[op_k];
                x_ss     = REQ_S[op_k];
                op_res   = x_ss ? x_sd : lut_init[x_si];
                m_ptr    = (op_k + 1) % N;
            end
            x_gnt = (op_act && e <= op_start + 1) ? (N'(1) << op_k) : '0;
            x_ack = op_act && (e == op_start + 2);
            if (x_ack) x_res = op_res;
        end
    end

    always @(negedge C) begin
        chk("gnt",  32'(GNT),  32'(x_gnt));
        chk("ack",  32'(ACK),  32'(x_ack));
        chk("res",  32'(RES),  32'(x_res));
        chk("sl_i", 32'(SL_I), 32'(x_si));
        chk("sl_d", 32'(SL_D), 32'(x_sd));
        chk("sl_s", 32'(SL_S), 32'(x_ss));
    end

    logic [N-1:0] glog [$];
    int           gcyc [$];
    logic [N-1:0] prev_g = '0;
    int           ncyc = 0;

    always @(negedge C) begin
        if (GNT != '0 && prev_g == '0) begin
            glog.push_back(GNT);
            gcyc.push_back(ncyc);
        end
        prev_g = GNT;
        ncyc++;
    end

    task automatic run_op(input logic [N-1:0] r, output logic [N-1:0] g, output logic res,
                          output int gcnt, output int lat);
        int t;
        REQ = r; g = '0; res = 0; gcnt = 0; lat = 0; t = 0;
        while (GNT == '0 && t < 12) begin tick(); t++; end
        chk("op_grant_seen", 32'(GNT != '0), 32'd1);
        g = GNT;
        REQ = '0;
        lat = 1;
        while (!ACK && lat < 12) begin
            if (GNT != '0) gcnt++;
            tick();
            lat++;
        end
        chk("op_ack_seen", 32'(ACK), 32'd1);
        res = RES;
        tick();
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (glog.size() < n && t < 40) begin tick(); t++; end
        chk("grant_count_reached", 32'(glog.size() >= n), 32'd1);
    endtask

    logic [N-1:0] g;
    logic         r;
    int           gc, lat, acks;
    logic [N-1:0] fair_exp [5];

    initial begin
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;

        tick(); tick();
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_res", 32'(RES), 0);
        chk("rst_sl_i", 32'(SL_I), 0);
        chk("rst_sl_d", 32'(SL_D), 0);
        chk("rst_sl_s", 32'(SL_S), 0);
        RN = 1'b1;
        tick();

        // LUT index 10 of INIT 6C5A is 1
        REQ_I = 16'h000A; REQ_D = '0; REQ_S = '0;
        run_op(4'b0001, g, r, gc, lat);
        chk("single_gnt", 32'(g), 32'h1);
        chk("single_res", 32'(r), 1);
        chk("single_gnt_cycles", 32'(gc), 2);
        chk("single_latency", 32'(lat), 3);

        REQ_I = 16'h0000; REQ_D = 4'b0100; REQ_S = 4'b0100;
        run_op(4'b0100, g, r, gc, lat);
        chk("bypass_gnt", 32'(g), 32'h4);
        chk("bypass_res1", 32'(r), 1);
        chk("bypass_sl_s", 32'(SL_S), 1);
        REQ_D = 4'b0000;
        run_op(4'b0100, g, r, gc, lat);
        chk("bypass_res0", 32'(r), 0);

        // pointer now 3
        glog.delete(); gcyc.delete();
        REQ_I = 16'h5A3C; REQ_D = 4'b1001; REQ_S = 4'b0001;
        REQ = 4'b1001;
        wait_grants(2);
        REQ = '0;
        repeat (4) tick();
        chk("wrap_first", 32'(glog[0]), 32'h8);
        chk("wrap_second", 32'(glog[1]), 32'h1);
        chk("wrap_spacing", 32'(gcyc[1] - gcyc[0]), 3);

        run_op(4'b1000, g, r, gc, lat);
        chk("ptr_realign_gnt", 32'(g), 32'h8);

        glog.delete(); gcyc.delete();
        REQ_I = 16'h3A5C; REQ_D = 4'b0110; REQ_S = 4'b0101;
        REQ = 4'b1111;
        wait_grants(5);
        REQ = '0;
        repeat (4) tick();
        chk("fair_total", 32'(glog.size()), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_grant%0d", i), 32'(glog[i]), 32'(fair_exp[i]));
            if (i > 0) chk($sformatf("fair_spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 3);
        end

        // reset during ISSUE
        REQ_I = 16'h000A; REQ_S = '0; REQ_D = '0;
        REQ = 4'b0001;
        @(posedge C);
        #1;
        chk("mid_gnt_pre", 32'(GNT), 32'h1);
        #1;
        RN = 1'b0;
        #1;
        chk("mid_gnt", 32'(GNT), 0);
        chk("mid_ack", 32'(ACK), 0);
        chk("mid_res", 32'(RES), 0);
        chk("mid_sl_i", 32'(SL_I), 0);
        REQ = '0;
        tick(); tick();
        RN = 1'b1;
        acks = 0;
        repeat (6) begin tick(); if (ACK) acks++; end
        chk("mid_no_ack", 32'(acks), 0);

        run_op(4'b0010, g, r, gc, lat);
        chk("post_rst_gnt", 32'(g), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
